neuron_accumulator: RTL and testbench

- Consumes the 33 per-synapse products (32 weighted inputs plus one bias term) from the neuron multiplier array.
- Reduces them to a single saturated 32-bit pre-activation sum.
- Sums sequentially, one term per cycle, to keep area small.
- Uses valid/ready handshakes upstream (product capture) and downstream (activation stage).

---
 rtl/neuron_accumulator.sv | 113 +++++++++++
 tb/tb_neuron_accumulator.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/neuron_accumulator.sv
// Sequential reducer for one neuron evaluation: captures N_TERMS signed products,
// adds one per cycle into a wide accumulator and presents a saturated DATA_W sum.
module neuron_accumulator #(
  parameter int N_TERMS = 33,
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 40
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_TERMS-1:0][DATA_W-1:0]  products,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_W-1:0]               sum,
  output logic                            sat,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                           state, state_next;
  logic [CNT_W-1:0]                 count, count_next;
  logic signed [ACC_W-1:0]          acc, acc_next, acc_sum;
  logic [N_TERMS-1:0][DATA_W-1:0]   cap;
  logic [DATA_W-1:0]                term;
  logic [DATA_W-1:0]                sum_next, sum_sat;
  logic                             sat_next, sat_flag;
  logic                             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Upstream products are only sampled on the accept edge; later changes are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap <= '0;
    end else if (accept) begin
      cap <= products;
    end
  end

  assign term    = (count <= LAST) ? cap[count] : '0;
  assign acc_sum = acc + {{(ACC_W-DATA_W){term[DATA_W-1]}}, term};

  always_comb begin
    sum_sat  = acc_sum[DATA_W-1:0];
    sat_flag = 1'b0;
    if (acc_sum > SAT_MAX) begin
      sum_sat  = {1'b0, {(DATA_W-1){1'b1}}};
      sat_flag = 1'b1;
    end else if (acc_sum < SAT_MIN) begin
      sum_sat  = {1'b1, {(DATA_W-1){1'b0}}};
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    acc_next   = acc;
    sum_next   = sum;
    sat_next   = sat;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_next   = '0;
          count_next = '0;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        acc_next = acc_sum;
        if (count == LAST) begin
          sum_next   = sum_sat;
          sat_next   = sat_flag;
          state_next = DONE;
        end else begin
          count_next = count + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      sum   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      acc   <= acc_next;
      sum   <= sum_next;
      sat   <= sat_next;
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: hand-computed sums, latency, backpressure, async reset.
module tb_neuron_accumulator;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [32:0][31:0]    products;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          sum;
  logic                 sat;
  logic                 out_valid;
  logic                 out_ready;

  int total = 0;
  int bad   = 0;

  neuron_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .products  (products),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 33; i++) products[i] = v;
  endtask

  // Accept the current products, then count edges until out_valid.
  task automatic start_and_wait(input string tag);
    int lat;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd33);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid_low"}, 64'(out_valid), 64'd0);
  endtask

  task automatic eval(input string tag, input logic [31:0] exp_sum, input logic exp_sat);
    start_and_wait(tag);
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_sat"}, 64'(sat), 64'(exp_sat));
    $display("txn %s: sum=%08h sat=%0d", tag, sum, sat);
    release_out(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fill(32'd0);
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    fill(32'd1);
    eval("ones", 32'd33, 1'b0);

    for (int i = 0; i < 33; i++) products[i] = 32'(i - 16);
    eval("ramp", 32'd0, 1'b0);

    fill(32'h7FFF_FFFF);
    eval("pos_sat", 32'h7FFF_FFFF, 1'b1);

    fill(32'h8000_0000);
    eval("neg_sat", 32'h8000_0000, 1'b1);

    fill(32'd0); products[0] = 32'h7FFF_FFFE; products[1] = 32'd1;
    eval("edge_max", 32'h7FFF_FFFF, 1'b0);

    products[2] = 32'd1;
    eval("edge_over", 32'h7FFF_FFFF, 1'b1);

    // Backpressure: first set sums to 66; later sets on the bus must be ignored.
    fill(32'd2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    fill(32'd5);
    for (int c = 0; c < 40 && !out_valid; c++) begin
      in_valid = c[0];
      @(posedge clk); #1;
    end
    check("bp_out_valid", 64'(out_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      in_valid = ~c[0];
      products[0] = 32'(c + 100);
      @(posedge clk); #1;
      check("bp_sum_hold", 64'(sum), 64'd66);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    $display("txn backpressure: sum=%08h sat=%0d", sum, sat);
    release_out("bp");

    // Asynchronous reset in the 10th accumulate cycle aborts the evaluation.
    fill(32'd3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_sum", 64'(sum), 64'd0);
    check("arst_sat", 64'(sat), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    $display("txn async_reset: sum=%08h in_ready=%0d", sum, in_ready);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    fill(32'd1);
    eval("post_rst", 32'd33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
